// File: rtl/glenn_scan_sequencer.sv
// Scan sequencer driving a 3-to-8 decoder: steps sel/en through the channels
// enabled in a latched mask, with a programmable dwell and a one-cycle gap between channels.
module glenn_scan_sequencer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [7:0]         ch_mask,
   output logic [2:0]         sel,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DWELL,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;
   logic [7:0]         mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q, cont_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;

   logic [DWELL_W-1:0] dwell_eff;
   logic [2:0]         first_idx;
   logic               first_found;
   logic [2:0]         next_idx;
   logic               next_found;
   logic [2:0]         cand;

   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

   // Lowest set bit of the incoming mask, and next set latched bit above sel (wrapping).
   always_comb begin
      first_idx   = '0;
      first_found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (!first_found && ch_mask[i]) begin
            first_idx   = 3'(i);
            first_found = 1'b1;
         end
      end
      next_idx   = sel_q;
      next_found = 1'b0;
      cand       = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         cand = sel_q + 3'(i);
         if (!next_found && mask_q[cand]) begin
            next_idx   = cand;
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      en_d    = en_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      cont_d  = cont_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            en_d = 1'b0;
            if (start) begin
               if (ch_mask != '0) begin
                  mask_d  = ch_mask;
                  dwell_d = dwell_eff;
                  cont_d  = continuous;
                  sel_d   = first_idx;
                  en_d    = 1'b1;
                  cnt_d   = dwell_eff - DWELL_W'(1);
                  state_d = S_DWELL;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_DWELL: begin
            if (stop) begin
               state_d = S_IDLE;
               en_d    = 1'b0;
            end else if (cnt_q == '0) begin
               en_d = 1'b0;
               // A non-increasing next index means the sweep has wrapped.
               if (next_idx <= sel_q) begin
                  if (cont_q) begin
                     state_d = S_GAP;
                     sel_d   = next_idx;
                     wrap_d  = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  state_d = S_GAP;
                  sel_d   = next_idx;
               end
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_GAP: begin
            if (stop) begin
               state_d = S_IDLE;
               en_d    = 1'b0;
            end else begin
               state_d = S_DWELL;
               en_d    = 1'b1;
               cnt_d   = dwell_q - DWELL_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         mask_q  <= '0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         mask_q  <= mask_d;
         dwell_q <= dwell_d;
         cont_q  <= cont_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sel  = sel_q;
   assign en   = en_q;
   assign busy = busy_q;
   assign done = done_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_glenn_scan_sequencer.sv
// Self-checking bench for glenn_scan_sequencer: directed vector table, hand-written
// corner sequences, and randomized scans compared against a trace-level model.
module tb_glenn_scan_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       continuous;
   logic [7:0] dwell;
   logic [7:0] ch_mask;
   logic [2:0] sel;
   logic       en;
   logic       busy;
   logic       done;
   logic       wrap;

   glenn_scan_sequencer #(.DWELL_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .dwell      (dwell),
      .ch_mask    (ch_mask),
      .sel        (sel),
      .en         (en),
      .busy       (busy),
      .done       (done),
      .wrap       (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic       busy;
      logic       done;
      logic       wrap;
   } obs_t;

   typedef struct {
      logic [7:0]  mask;
      int unsigned dw;
      int unsigned exp_busy;
      int unsigned exp_en;
      int unsigned exp_done;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   obs_t exp_q[$];
   int unsigned model_sel = 0;

   function automatic obs_t mk(input int unsigned s, input bit e, input bit b,
                               input bit d, input bit w);
      obs_t r;
      r.sel  = 3'(s);
      r.en   = e;
      r.busy = b;
      r.done = d;
      r.wrap = w;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_obs(input string name, input obs_t exp);
      obs_t act;
      act = {sel, en, busy, done, wrap};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got sel=%0d en=%b busy=%b done=%b wrap=%b, expected sel=%0d en=%b busy=%b done=%b wrap=%b",
                  name, act.sel, act.en, act.busy, act.done, act.wrap,
                  exp.sel, exp.en, exp.busy, exp.done, exp.wrap);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected outputs after each clock edge following the start edge, built
   // from the channel list: dwell cycles per channel, a gap between channels,
   // then either done (single) or a wrap gap back to the first channel.
   task automatic build_trace(input logic [7:0] m, input int unsigned dw, input bit cont,
                              input int unsigned sweeps, input int unsigned cur_sel);
      int unsigned chans[$];
      int unsigned d;
      d = (dw == 0) ? 1 : dw;
      exp_q.delete();
      for (int c = 0; c < 8; c++) if (m[c]) chans.push_back(c);
      if (chans.size() == 0) begin
         exp_q.push_back(mk(cur_sel, 0, 0, 1, 0));
         return;
      end
      for (int unsigned s = 0; s < sweeps; s++) begin
         for (int k = 0; k < chans.size(); k++) begin
            for (int unsigned j = 0; j < d; j++) exp_q.push_back(mk(chans[k], 1, 1, 0, 0));
            if (k < chans.size() - 1) exp_q.push_back(mk(chans[k+1], 0, 1, 0, 0));
            else if (cont)            exp_q.push_back(mk(chans[0], 0, 1, 0, 1));
            else                      exp_q.push_back(mk(chans[k], 0, 0, 1, 0));
         end
         if (!cont) break;
      end
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{mask: 8'hA5, dw: 2,   exp_busy: 11,  exp_en: 8,   exp_done: 1};
      vecs[1] = '{mask: 8'h10, dw: 0,   exp_busy: 1,   exp_en: 1,   exp_done: 1};
      vecs[2] = '{mask: 8'hFF, dw: 1,   exp_busy: 15,  exp_en: 8,   exp_done: 1};
      vecs[3] = '{mask: 8'h81, dw: 0,   exp_busy: 3,   exp_en: 2,   exp_done: 1};
      vecs[4] = '{mask: 8'h80, dw: 3,   exp_busy: 3,   exp_en: 3,   exp_done: 1};
      vecs[5] = '{mask: 8'h01, dw: 255, exp_busy: 255, exp_en: 255, exp_done: 1};
      vecs[6] = '{mask: 8'h00, dw: 4,   exp_busy: 0,   exp_en: 0,   exp_done: 1};

      rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      dwell = 8'd0; ch_mask = 8'd0;
      #1;
      check_obs("reset_initial", mk(0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check_obs("idle_after_reset", mk(0, 0, 0, 0, 0));

      // Directed single-sweep table
      for (int v = 0; v < 7; v++) begin
         int unsigned nb, ne, nd, ninv, win, d;
         nb = 0; ne = 0; nd = 0; ninv = 0;
         d = (vecs[v].dw == 0) ? 1 : vecs[v].dw;
         win = 8 * (d + 1) + 8;
         ch_mask = vecs[v].mask; dwell = 8'(vecs[v].dw); continuous = 1'b0;
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int unsigned c = 0; c < win; c++) begin
            if (busy) nb++;
            if (en) ne++;
            if (done) nd++;
            if (en && !vecs[v].mask[sel]) ninv++;
            tick();
         end
         check_val($sformatf("vec%0d_busy_cycles", v), int'(nb), int'(vecs[v].exp_busy));
         check_val($sformatf("vec%0d_en_cycles", v), int'(ne), int'(vecs[v].exp_en));
         check_val($sformatf("vec%0d_done_pulses", v), int'(nd), int'(vecs[v].exp_done));
         check_val($sformatf("vec%0d_en_mask_invariant", v), int'(ninv), 0);
      end

      // Reset asserted mid-scan clears outputs asynchronously and holds them
      ch_mask = 8'hA5; dwell = 8'd2; continuous = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      check_obs("reset_async_midscan", mk(0, 0, 0, 0, 0));
      repeat (3) @(posedge clk);
      #1;
      check_obs("reset_held", mk(0, 0, 0, 0, 0));
      rst = 1'b0;
      tick();
      check_obs("idle_after_midscan_reset", mk(0, 0, 0, 0, 0));

      // Continuous scan with wrap pulses, then stop
      begin
         int unsigned wraps, dones, cyc;
         wraps = 0; dones = 0; cyc = 0;
         ch_mask = 8'h82; dwell = 8'd1; continuous = 1'b1;
         start = 1'b1;
         tick();
         start = 1'b0;
         check_obs("cont_first", mk(1, 1, 1, 0, 0));
         while (wraps < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done) dones++;
            if (wrap) begin
               wraps++;
               check_obs("cont_wrap_gap", mk(1, 0, 1, 0, 1));
            end
         end
         check_val("cont_wrap_count", int'(wraps), 3);
         stop = 1'b1;
         tick();
         stop = 1'b0;
         check_obs("cont_after_stop", mk(1, 0, 0, 0, 0));
         tick();
         check_obs("cont_idle_no_done", mk(1, 0, 0, 0, 0));
         check_val("cont_done_count", int'(dones), 0);
      end

      // Start and input changes while busy are ignored
      begin
         obs_t seq[5];
         seq[0] = mk(0, 1, 1, 0, 0);
         seq[1] = mk(1, 0, 1, 0, 0);
         seq[2] = mk(1, 1, 1, 0, 0);
         seq[3] = mk(1, 0, 0, 1, 0);
         seq[4] = mk(1, 0, 0, 0, 0);
         ch_mask = 8'h03; dwell = 8'd1; continuous = 1'b0;
         start = 1'b1;
         tick();
         check_obs("ignore_s0", seq[0]);
         ch_mask = 8'hFF; dwell = 8'd9; continuous = 1'b1;
         for (int i = 1; i < 5; i++) begin
            if (i == 3) start = 1'b0;
            tick();
            check_obs($sformatf("ignore_s%0d", i), seq[i]);
         end
         start = 1'b0;
      end

      // Empty mask: done pulse only
      ch_mask = 8'h00; dwell = 8'd3; continuous = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_obs("empty_done", mk(1, 0, 0, 1, 0));
      tick();
      check_obs("empty_after", mk(1, 0, 0, 0, 0));
      model_sel = 1;

      // Randomized scans against the trace model
      for (int t = 0; t < 40; t++) begin
         logic [7:0]  m;
         int unsigned dw;
         bit          c;
         int          stop_at;
         obs_t        e;
         m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         dw = $urandom_range(0, 4);
         c  = 1'($urandom_range(0, 1));
         build_trace(m, dw, c, c ? 3 : 1, model_sel);
         stop_at = 0;
         if (exp_q.size() > 1 && (c || $urandom_range(0, 3) == 0))
            stop_at = $urandom_range(1, exp_q.size() - 1);
         ch_mask = m; dwell = 8'(dw); continuous = c;
         start = 1'b1;
         tick();
         start = 1'b0;
         check_obs($sformatf("rand%0d_c0", t), exp_q[0]);
         model_sel = exp_q[0].sel;
         for (int k = 1; k < exp_q.size(); k++) begin
            if (exp_q[k-1].busy) begin
               ch_mask    = 8'($urandom);
               dwell      = 8'($urandom);
               continuous = 1'($urandom);
               start      = 1'($urandom_range(0, 1));
            end
            if (k == stop_at) begin
               stop = 1'b1;
               tick();
               stop = 1'b0;
               start = 1'b0;
               e = mk(exp_q[k-1].sel, 0, 0, 0, 0);
               check_obs($sformatf("rand%0d_stop_c%0d", t, k), e);
               model_sel = e.sel;
               break;
            end
            tick();
            check_obs($sformatf("rand%0d_c%0d", t, k), exp_q[k]);
            model_sel = exp_q[k].sel;
         end
         start = 1'b0;
         if (stop_at == 0) begin
            tick();
            check_obs($sformatf("rand%0d_idle", t), mk(model_sel, 0, 0, 0, 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
